// File: rtl/ct_clint_ncore_func.sv
// Multi-hart CLINT behind a three-state APB slave: MSIP/SSIP banks, per-hart timer compares, read-only MTIME.
// Optional STIMECMP bank and clint_st_int are built only when CLINT_STIMECMP_EN is defined.

module ct_clint_hart (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic [63:0] mtime,
  input  logic [31:0] wdata,
  input  logic        wr_msip,
  input  logic        wr_ssip,
  input  logic        wr_mcmp_lo,
  input  logic        wr_mcmp_hi,
`ifdef CLINT_STIMECMP_EN
  input  logic        wr_scmp_lo,
  input  logic        wr_scmp_hi,
  output logic [63:0] stimecmp,
`endif
  output logic        msip,
  output logic        ssip,
  output logic [63:0] mtimecmp,
  output logic        mt_int,
  output logic        st_int
);
  logic        msip_q, msip_d, ssip_q, ssip_d, mt_int_q, mt_int_d;
  logic [63:0] mcmp_q, mcmp_d;

  always_comb begin
    msip_d   = wr_msip ? wdata[0] : msip_q;
    ssip_d   = wr_ssip ? wdata[0] : ssip_q;
    mcmp_d   = mcmp_q;
    if (wr_mcmp_lo) mcmp_d[31:0]  = wdata;
    if (wr_mcmp_hi) mcmp_d[63:32] = wdata;
    // Compare uses the stored value, so a same-cycle write only shows up next cycle.
    mt_int_d = (mtime >= mcmp_q);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      msip_q   <= 1'b0;
      ssip_q   <= 1'b0;
      mcmp_q   <= '1;
      mt_int_q <= 1'b0;
    end else begin
      msip_q   <= msip_d;
      ssip_q   <= ssip_d;
      mcmp_q   <= mcmp_d;
      mt_int_q <= mt_int_d;
    end
  end

  assign msip     = msip_q;
  assign ssip     = ssip_q;
  assign mtimecmp = mcmp_q;
  assign mt_int   = mt_int_q;

`ifdef CLINT_STIMECMP_EN
  logic [63:0] scmp_q, scmp_d;
  logic        st_int_q, st_int_d;

  always_comb begin
    scmp_d = scmp_q;
    if (wr_scmp_lo) scmp_d[31:0]  = wdata;
    if (wr_scmp_hi) scmp_d[63:32] = wdata;
    st_int_d = (mtime >= scmp_q);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      scmp_q   <= '1;
      st_int_q <= 1'b0;
    end else begin
      scmp_q   <= scmp_d;
      st_int_q <= st_int_d;
    end
  end

  assign stimecmp = scmp_q;
  assign st_int   = st_int_q;
`else
  assign st_int = 1'b0;
`endif
endmodule

module ct_clint_ncore_func #(
  parameter int          NUM_CORES = 4,
  parameter logic [15:0] BASE_SSIP = 16'hC000
) (
  input  logic                 forever_apbclk,
  input  logic                 cpurst_b,
  input  logic                 apb_clk_en,
  input  logic                 psel_clint,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [31:0]          paddr,
  input  logic [31:0]          pwdata,
  input  logic [1:0]           pprot,
  output logic [31:0]          prdata_clint,
  output logic                 pready_clint,
  output logic                 perr_clint,
  input  logic [63:0]          sysio_clint_mtime,
  output logic [NUM_CORES-1:0] clint_ms_int,
  output logic [NUM_CORES-1:0] clint_mt_int,
  output logic [NUM_CORES-1:0] clint_ss_int,
  output logic [NUM_CORES-1:0] clint_st_int
);
  localparam int          HW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [11:0] NC12 = 12'(NUM_CORES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        pready_q, pready_d, perr_q, perr_d;
  logic [31:0] prdata_q, prdata_d;
  logic        commit;

  logic [15:0] off;
  logic [16:0] srel;
  logic [11:0] raw_idx;
  logic [HW-1:0] hart;
  logic        sel_msip, sel_ssip, sel_mcmp, sel_scmp, sel_mtime, hi;
  logic        needs_idx, dec_err, we;
  logic [31:0] rdata;

  logic [NUM_CORES-1:0]       wr_msip, wr_ssip, wr_mcmp_lo, wr_mcmp_hi, wr_scmp_lo, wr_scmp_hi;
  logic [NUM_CORES-1:0][63:0] mcmp, scmp;

  // Address decode; addresses below BASE_SSIP borrow into srel[16].
  always_comb begin
    off       = paddr[15:0];
    srel      = {1'b0, off} - {1'b0, BASE_SSIP};
    sel_msip  = 1'b0;
    sel_ssip  = 1'b0;
    sel_mcmp  = 1'b0;
    sel_scmp  = 1'b0;
    sel_mtime = 1'b0;
    hi        = off[2];
    raw_idx   = '0;
    if (off[15:14] == 2'b00) begin
      sel_msip = 1'b1;
      raw_idx  = off[13:2];
    end else if (off[15:14] == 2'b01) begin
      sel_mcmp = 1'b1;
      raw_idx  = {1'b0, off[13:3]};
    end else if (off[15:3] == 13'h17FF) begin
      sel_mtime = 1'b1;
    end else if (!srel[16] && srel[15:12] == 4'h0) begin
      sel_ssip = 1'b1;
      raw_idx  = {2'b0, srel[11:2]};
`ifdef CLINT_STIMECMP_EN
    end else if (!srel[16] && srel[15:12] == 4'h1) begin
      sel_scmp = 1'b1;
      hi       = srel[2];
      raw_idx  = {3'b0, srel[11:3]};
`endif
    end
    hart      = raw_idx[HW-1:0];
    needs_idx = sel_msip | sel_mcmp | sel_ssip | sel_scmp;
    dec_err   = !(needs_idx | sel_mtime) | (needs_idx & (raw_idx >= NC12)) |
                !pprot[0] | (sel_mtime & pwrite);
    rdata = '0;
    if (sel_msip)  rdata = {31'b0, clint_ms_int[hart]};
    if (sel_ssip)  rdata = {31'b0, clint_ss_int[hart]};
    if (sel_mcmp)  rdata = hi ? mcmp[hart][63:32] : mcmp[hart][31:0];
    if (sel_scmp)  rdata = hi ? scmp[hart][63:32] : scmp[hart][31:0];
    if (sel_mtime) rdata = hi ? sysio_clint_mtime[63:32] : sysio_clint_mtime[31:0];
  end

  always_comb begin
    state_d  = state_q;
    pready_d = pready_q;
    perr_d   = perr_q;
    prdata_d = prdata_q;
    commit   = 1'b0;
    if (apb_clk_en) begin
      case (state_q)
        S_IDLE:   if (psel_clint && penable) state_d = S_ACCESS;
        S_ACCESS: begin
          state_d  = S_RESP;
          commit   = 1'b1;
          pready_d = 1'b1;
          perr_d   = dec_err;
          prdata_d = (pwrite || dec_err) ? 32'h0 : rdata;
        end
        S_RESP: begin
          state_d  = S_IDLE;
          pready_d = 1'b0;
          perr_d   = 1'b0;
          prdata_d = 32'h0;
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge forever_apbclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= S_IDLE;
      pready_q <= 1'b0;
      perr_q   <= 1'b0;
      prdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pready_q <= pready_d;
      perr_q   <= perr_d;
      prdata_q <= prdata_d;
    end
  end

  assign we = commit & pwrite & !dec_err;

  always_comb begin
    wr_msip    = '0;
    wr_ssip    = '0;
    wr_mcmp_lo = '0;
    wr_mcmp_hi = '0;
    wr_scmp_lo = '0;
    wr_scmp_hi = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      if (we && hart == HW'(n)) begin
        wr_msip[n]    = sel_msip;
        wr_ssip[n]    = sel_ssip;
        wr_mcmp_lo[n] = sel_mcmp & !hi;
        wr_mcmp_hi[n] = sel_mcmp & hi;
        wr_scmp_lo[n] = sel_scmp & !hi;
        wr_scmp_hi[n] = sel_scmp & hi;
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_hart
    ct_clint_hart u_hart (
      .gclk       (forever_apbclk),
      .grst_n     (cpurst_b),
      .mtime      (sysio_clint_mtime),
      .wdata      (pwdata),
      .wr_msip    (wr_msip[g]),
      .wr_ssip    (wr_ssip[g]),
      .wr_mcmp_lo (wr_mcmp_lo[g]),
      .wr_mcmp_hi (wr_mcmp_hi[g]),
`ifdef CLINT_STIMECMP_EN
      .wr_scmp_lo (wr_scmp_lo[g]),
      .wr_scmp_hi (wr_scmp_hi[g]),
      .stimecmp   (scmp[g]),
`endif
      .msip       (clint_ms_int[g]),
      .ssip       (clint_ss_int[g]),
      .mtimecmp   (mcmp[g]),
      .mt_int     (clint_mt_int[g]),
      .st_int     (clint_st_int[g])
    );
`ifndef CLINT_STIMECMP_EN
    assign scmp[g] = 64'h0;
`endif
  end

  logic unused_bits;
  assign unused_bits = ^{paddr[31:16], pprot[1], off[1:0], srel[1:0], wr_scmp_lo, wr_scmp_hi};

  assign prdata_clint = prdata_q;
  assign pready_clint = pready_q;
  assign perr_clint   = perr_q;
endmodule

// File: tb/tb_ct_clint_ncore_func.sv
// Directed bench for ct_clint_ncore_func (NUM_CORES=4): APB timing, banks, compares, errors and reset.
module tb_ct_clint_ncore_func;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        apb_clk_en = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [1:0]  pprot = 2'b01;
  logic [31:0] prdata;
  logic        pready, perr;
  logic [63:0] mtime = '0;
  logic [3:0]  ms_int, mt_int, ss_int, st_int;

  int vec = 0;
  int miss = 0;

  ct_clint_ncore_func #(.NUM_CORES(4), .BASE_SSIP(16'hC000)) dut (
    .forever_apbclk    (clk),
    .cpurst_b          (rst_n),
    .apb_clk_en        (apb_clk_en),
    .psel_clint        (psel),
    .penable           (penable),
    .pwrite            (pwrite),
    .paddr             (paddr),
    .pwdata            (pwdata),
    .pprot             (pprot),
    .prdata_clint      (prdata),
    .pready_clint      (pready),
    .perr_clint        (perr),
    .sysio_clint_mtime (mtime),
    .clint_ms_int      (ms_int),
    .clint_mt_int      (mt_int),
    .clint_ss_int      (ss_int),
    .clint_st_int      (st_int)
  );

  always #5 clk = ~clk;

  // Presents one transfer and returns 1ns after the edge that raises pready.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] prot, output logic [31:0] rd, output logic err,
                          output int lat);
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = wr; paddr = addr; pwdata = data; pprot = prot;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!pready && lat < 20);
    rd  = prdata;
    err = perr;
    if (!pready) begin
      vec++; miss++;
      $display("FAIL xfer_timeout addr=%h got pready=0 want 1", addr);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int lat;
    rst_n = 1'b0;
    #2;
    vec++; if ({pready, perr, prdata} !== 34'h0) begin miss++; $display("FAIL reset_apb got %b/%b/%h want 0/0/0", pready, perr, prdata); end
    vec++; if ({ms_int, mt_int, ss_int, st_int} !== 16'h0) begin miss++; $display("FAIL reset_irq got %h want 0", {ms_int, mt_int, ss_int, st_int}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    vec++; if (mt_int !== 4'b0) begin miss++; $display("FAIL reset_mt got %b want 0000", mt_int); end
    apb_xfer(1'b0, 32'h4018, 0, 2'b01, rd, err, lat);
    vec++; if (rd !== 32'hFFFF_FFFF || err !== 1'b0) begin miss++; $display("FAIL reset_mtimecmp3 got %h/%b want ffffffff/0", rd, err); end
  endtask

  task automatic test_msip();
    logic [31:0] rd; logic err; int lat;
    @(posedge clk); #1;
    apb_xfer(1'b1, 32'h000C, 32'h1, 2'b01, rd, err, lat);
    vec++; if (lat !== 2) begin miss++; $display("FAIL msip_latency got %0d want 2", lat); end
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL msip_err got %b want 0", err); end
    vec++; if (ms_int !== 4'b1000) begin miss++; $display("FAIL msip3_set got %b want 1000", ms_int); end
    @(posedge clk); #1;
    vec++; if (pready !== 1'b0) begin miss++; $display("FAIL pready_one_cycle got %b want 0", pready); end
    apb_xfer(1'b1, 32'h0000, 32'hFFFF_FFFF, 2'b01, rd, err, lat);
    vec++; if (ms_int !== 4'b1001) begin miss++; $display("FAIL msip0_bit0 got %b want 1001", ms_int); end
    apb_xfer(1'b0, 32'h0000, 0, 2'b01, rd, err, lat);
    vec++; if (rd !== 32'h1) begin miss++; $display("FAIL msip0_read got %h want 00000001", rd); end
    apb_xfer(1'b1, 32'h0000, 32'h0, 2'b01, rd, err, lat);
    apb_xfer(1'b1, 32'h000C, 32'h0, 2'b01, rd, err, lat);
    vec++; if (ms_int !== 4'b0000) begin miss++; $display("FAIL msip_clear got %b want 0000", ms_int); end
  endtask

  task automatic test_mtime_read();
    logic [31:0] rd; logic err; int lat;
    mtime = 64'h1234_5678_9ABC_DEF0;
    apb_xfer(1'b0, 32'hBFFC, 0, 2'b01, rd, err, lat);
    vec++; if (rd !== 32'h1234_5678 || err !== 1'b0) begin miss++; $display("FAIL mtime_hi got %h/%b want 12345678/0", rd, err); end
    apb_xfer(1'b0, 32'hBFF8, 0, 2'b01, rd, err, lat);
    vec++; if (rd !== 32'h9ABC_DEF0) begin miss++; $display("FAIL mtime_lo got %h want 9abcdef0", rd); end
  endtask

  task automatic test_mtimecmp();
    logic [31:0] rd; logic err; int lat;
    @(negedge clk); mtime = 64'h0;
    apb_xfer(1'b1, 32'h4008, 32'h0, 2'b01, rd, err, lat);
    apb_xfer(1'b1, 32'h400C, 32'h1, 2'b01, rd, err, lat);
    apb_xfer(1'b0, 32'h400C, 0, 2'b01, rd, err, lat);
    vec++; if (rd !== 32'h1) begin miss++; $display("FAIL mtimecmp1_hi got %h want 00000001", rd); end
    @(negedge clk); mtime = 64'h0000_0000_FFFF_FFFF;
    @(posedge clk); #1;
    vec++; if (mt_int !== 4'b0000) begin miss++; $display("FAIL mt_below got %b want 0000", mt_int); end
    @(negedge clk); mtime = 64'h0000_0001_0000_0000;
    #1;
    vec++; if (mt_int !== 4'b0000) begin miss++; $display("FAIL mt_latency got %b want 0000", mt_int); end
    @(posedge clk); #1;
    vec++; if (mt_int !== 4'b0010) begin miss++; $display("FAIL mt_rise got %b want 0010", mt_int); end
    apb_xfer(1'b1, 32'h400C, 32'h2, 2'b01, rd, err, lat);
    vec++; if (mt_int !== 4'b0010) begin miss++; $display("FAIL mt_prewrite got %b want 0010", mt_int); end
    @(posedge clk); #1;
    vec++; if (mt_int !== 4'b0000) begin miss++; $display("FAIL mt_postwrite got %b want 0000", mt_int); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(1'b1, 32'h0010, 32'h1, 2'b01, rd, err, lat);
    vec++; if (err !== 1'b1 || ms_int !== 4'b0) begin miss++; $display("FAIL err_hart4_wr got %b/%b want 1/0000", err, ms_int); end
    apb_xfer(1'b1, 32'h0000, 32'h1, 2'b00, rd, err, lat);
    vec++; if (err !== 1'b1 || ms_int !== 4'b0) begin miss++; $display("FAIL err_pprot_wr got %b/%b want 1/0000", err, ms_int); end
    apb_xfer(1'b1, 32'hBFF8, 32'h5, 2'b01, rd, err, lat);
    vec++; if (err !== 1'b1 || rd !== 32'h0) begin miss++; $display("FAIL err_mtime_wr got %b/%h want 1/0", err, rd); end
    apb_xfer(1'b0, 32'hBFFC, 0, 2'b00, rd, err, lat);
    vec++; if (err !== 1'b1 || rd !== 32'h0) begin miss++; $display("FAIL err_pprot_rd got %b/%h want 1/0", err, rd); end
    apb_xfer(1'b0, 32'h8000, 0, 2'b01, rd, err, lat);
    vec++; if (err !== 1'b1 || rd !== 32'h0) begin miss++; $display("FAIL err_unmapped_rd got %b/%h want 1/0", err, rd); end
    apb_xfer(1'b0, 32'h4020, 0, 2'b01, rd, err, lat);
    vec++; if (err !== 1'b1 || rd !== 32'h0) begin miss++; $display("FAIL err_mcmp4_rd got %b/%h want 1/0", err, rd); end
  endtask

  task automatic test_supervisor();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(1'b1, 32'hC008, 32'h3, 2'b01, rd, err, lat);
    vec++; if (err !== 1'b0 || ss_int !== 4'b0100) begin miss++; $display("FAIL ssip2_set got %b/%b want 0/0100", err, ss_int); end
    apb_xfer(1'b0, 32'hC008, 0, 2'b01, rd, err, lat);
    vec++; if (rd !== 32'h1) begin miss++; $display("FAIL ssip2_read got %h want 00000001", rd); end
    apb_xfer(1'b1, 32'hD000, 32'h0, 2'b01, rd, err, lat);
`ifdef CLINT_STIMECMP_EN
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL stimecmp_lo_wr got %b want 0", err); end
`else
    vec++; if (err !== 1'b1) begin miss++; $display("FAIL stimecmp_lo_wr got %b want 1", err); end
`endif
    apb_xfer(1'b1, 32'hD004, 32'h0, 2'b01, rd, err, lat);
    repeat (2) @(posedge clk); #1;
`ifdef CLINT_STIMECMP_EN
    vec++; if (st_int !== 4'b0001) begin miss++; $display("FAIL st_int got %b want 0001", st_int); end
`else
    vec++; if (st_int !== 4'b0000 || err !== 1'b1) begin miss++; $display("FAIL st_int_tied got %b/%b want 0000/1", st_int, err); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(1'b1, 32'h0004, 32'h1, 2'b01, rd, err, lat);
    apb_xfer(1'b1, 32'h0008, 32'h1, 2'b01, rd, err, lat);
    vec++; if (lat !== 3) begin miss++; $display("FAIL b2b_latency got %0d want 3", lat); end
    vec++; if (ms_int !== 4'b0110) begin miss++; $display("FAIL b2b_msip got %b want 0110", ms_int); end
  endtask

  task automatic test_clk_en();
    @(posedge clk); #1;
    @(negedge clk);
    apb_clk_en = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h0; pprot = 2'b01;
    repeat (3) @(posedge clk); #1;
    vec++; if (pready !== 1'b0 || ms_int !== 4'b0110) begin miss++; $display("FAIL clken_idle_hold got %b/%b want 0/0110", pready, ms_int); end
    @(negedge clk); apb_clk_en = 1'b1;
    @(posedge clk); #1;
    apb_clk_en = 1'b0; psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk); #1;
    vec++; if (pready !== 1'b0 || ms_int !== 4'b0110) begin miss++; $display("FAIL clken_access_hold got %b/%b want 0/0110", pready, ms_int); end
    @(negedge clk); apb_clk_en = 1'b1;
    @(posedge clk); #1;
    vec++; if (pready !== 1'b1 || perr !== 1'b0 || ms_int !== 4'b0100) begin miss++; $display("FAIL clken_resp got %b/%b/%b want 1/0/0100", pready, perr, ms_int); end
    pwrite = 1'b0;
    @(posedge clk); #1;
    vec++; if (pready !== 1'b0) begin miss++; $display("FAIL clken_idle got %b want 0", pready); end
  endtask

  task automatic test_reset_midxfer();
    logic [31:0] rd; logic err; int lat;
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h1; pprot = 2'b01;
    @(posedge clk); #1;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    #1;
    vec++; if (pready !== 1'b0 || ms_int !== 4'b0) begin miss++; $display("FAIL rst_mid_async got %b/%b want 0/0000", pready, ms_int); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; pwrite = 1'b0;
    repeat (2) @(posedge clk); #1;
    vec++; if (pready !== 1'b0 || ms_int !== 4'b0 || mt_int !== 4'b0) begin miss++; $display("FAIL rst_mid_after got %b/%b/%b want 0/0000/0000", pready, ms_int, mt_int); end
    apb_xfer(1'b0, 32'h4000, 0, 2'b01, rd, err, lat);
    vec++; if (rd !== 32'hFFFF_FFFF) begin miss++; $display("FAIL rst_mtimecmp0 got %h want ffffffff", rd); end
    apb_xfer(1'b0, 32'h400C, 0, 2'b01, rd, err, lat);
    vec++; if (rd !== 32'hFFFF_FFFF) begin miss++; $display("FAIL rst_mtimecmp1_hi got %h want ffffffff", rd); end
  endtask

  initial begin
    test_reset();
    test_msip();
    test_mtime_read();
    test_mtimecmp();
    test_errors();
    test_supervisor();
    test_back_to_back();
    test_clk_en();
    test_reset_midxfer();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/ct_clint_ncore_func.md
CT_CLINT_NCORE_FUNC -- requirements
Module: ct_clint_ncore_func

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of harts served, legal range 1..8.
REQ-002 SHALL have parameter BASE_SSIP, default 16'hC000, offset of the supervisor-software-interrupt bank.
REQ-003 SHALL have port forever_apbclk  in  1  sole clock.
REQ-004 SHALL have port cpurst_b  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port apb_clk_en  in  1  APB clock enable; the APB state advances only when high.
REQ-006 SHALL have ports psel_clint, penable, pwrite  in  1 each  APB select, enable and direction.
REQ-007 SHALL have ports paddr  in  32, pwdata  in  32, pprot  in  2  APB address, write data and protection.
REQ-008 SHALL have ports prdata_clint  out  32, pready_clint  out  1, perr_clint  out  1  APB response.
REQ-009 SHALL have port sysio_clint_mtime  in  64  free-running platform time.
REQ-010 SHALL have ports clint_ms_int, clint_mt_int, clint_ss_int, clint_st_int  out  NUM_CORES each  per-hart interrupt vectors.

Function
REQ-011 SHALL decode paddr[15:0]:
  - MSIP[n] at 0x0000+4n (bit0).
  - MTIMECMP[n] lo/hi at 0x4000+8n / +4.
  - MTIME lo/hi at 0xBFF8 / 0xBFFC, read-only.
  - SSIP[n] at BASE_SSIP+4n (bit0).
  - STIMECMP[n] lo/hi at BASE_SSIP+0x1000+8n / +4.
REQ-012 SHALL run the APB FSM through IDLE -> ACCESS -> RESP -> IDLE, each transition taken only on an apb_clk_en cycle.
  - IDLE -> ACCESS on psel_clint & penable.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
REQ-013 SHALL drive pready_clint high for exactly the RESP cycle and low otherwise.
REQ-014 SHALL drive prdata_clint and perr_clint valid only during RESP, and 0 otherwise.
REQ-015 SHALL raise perr_clint in RESP when:
  - the offset is unmapped; or
  - the hart index is >= NUM_CORES; or
  - pprot[0]==0; or
  - a write targets MTIME.
REQ-016 SHALL ignore an erroring write and return 0 on an erroring read.
REQ-017 SHALL commit writes on the ACCESS->RESP edge, using paddr/pwdata sampled in ACCESS.
REQ-018 SHALL write only bit0 of MSIP/SSIP and read the upper bits as 0.
REQ-019 SHALL drive clint_ms_int[n]=MSIP[n] and clint_ss_int[n]=SSIP[n] from the register outputs, with no added latency.
REQ-020 SHALL register clint_mt_int[n] = (sysio_clint_mtime >= MTIMECMP[n]) as an unsigned 64-bit compare, with 1-cycle latency; clint_st_int uses the same rule with STIMECMP.
REQ-021 SHALL compare against the pre-write MTIMECMP value in the cycle it is written, and against the new value from the next cycle.
REQ-022 SHALL apply compare updates every clock, independent of apb_clk_en.
REQ-023 SHALL treat lo and hi halves as independent 32-bit writes with no atomic pairing; an intermediate compare result is architecturally visible.
REQ-024 SHALL accept back-to-back transfers, with a new ACCESS entered at the earliest on the IDLE cycle after RESP.
REQ-025 SHALL hold state if psel_clint drops mid-transfer, completing RESP regardless.

Reset
REQ-026 SHALL, while cpurst_b is low, asynchronously set:
  - FSM to IDLE;
  - MSIP and SSIP to 0;
  - MTIMECMP and STIMECMP to all-ones;
  - all four interrupt vectors to 0;
  - prdata_clint, pready_clint and perr_clint to 0.
REQ-027 SHALL abandon an in-flight transfer on reset, with no register modified.

Configuration
REQ-028 SHALL, with CLINT_STIMECMP_EN defined, implement the STIMECMP bank and clint_st_int as in REQ-011/020.
REQ-029 SHALL, without CLINT_STIMECMP_EN, remove the STIMECMP storage, tie clint_st_int to 0, and return perr_clint on STIMECMP offsets.

Verification
REQ-030 SHALL cover: NUM_CORES=4, write 0x1 to 0x000C -> clint_ms_int=4'b1000; pready high for one cycle, 2 apb_clk_en cycles after ACCESS starts.
REQ-031 SHALL cover: MTIMECMP[1]=0x0000_0001_0000_0000, mtime stepping 0xFFFF_FFFF -> 0x1_0000_0000 -> clint_mt_int[1] rises exactly 1 cycle after mtime reaches 0x1_0000_0000.
REQ-032 SHALL cover: write to 0x0010 with NUM_CORES=4, write with pprot=2'b00, and write to 0xBFF8 -> each gives perr_clint=1, registers unchanged, read data 0.
REQ-033 SHALL cover: read 0xBFFC with mtime=0x1234_5678_9ABC_DEF0 -> prdata_clint=0x1234_5678.
REQ-034 SHALL cover: cpurst_b asserted during ACCESS of an MSIP write -> MSIP stays 0, pready_clint=0, MTIMECMP reads 0xFFFF_FFFF after release.
REQ-035 SHALL cover: build without CLINT_STIMECMP_EN, with STIMECMP[0]=0 attempted -> perr_clint=1, clint_st_int stays 0.
